// File: rtl/debug_pbus_target.sv
// debug_pbus_target
// Responder on the CPU-domain debug memory bus. Serves a word-organised local
// RAM window (program buffer / debug data area) with a configurable number of
// wait states, byte-strobe writes and a sticky out-of-window error flag.
//
// Ports:
//   CLK      CPU clock, rising edge
//   RST_N    asynchronous active-low reset
//   PVALID   request valid, held by the initiator until it sees PREADY
//   PREADY   one-cycle response strobe
//   PWSTB    byte write strobes, 4'b0000 = read
//   PADDR    byte address (bits [1:0] ignored)
//   PWDATA   write data
//   PRDATA   read data, valid with PREADY and held until the next completed read
//   ERR      sticky out-of-window flag
//   ERR_CLR  synchronous clear of ERR (a simultaneous miss wins)
//   BUSY     high whenever the FSM is not idle
module debug_pbus_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0800,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PVALID,
  output logic        PREADY,
  input  logic [3:0]  PWSTB,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        ERR,
  input  logic        ERR_CLR,
  output logic        BUSY
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstb_r;
  logic [3:0]  cnt_r;
  logic        pready_r;
  logic        busy_r;
  logic        err_r;
  logic [31:0] prdata_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic [31:0]   req_addr_s;
  logic [3:0]    req_wstb_s;
  logic [31:0]   offset_s;
  logic          hit_s;
  logic [AW-1:0] idx_s;
  logic          req_read_s;
  logic [31:0]   rd_word_s;

  // Merge new data into an existing word, only on lanes whose strobe is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  stb);
    logic [31:0] m;
    m = old_w;
    for (int n = 0; n < 4; n++) begin
      m[8*n +: 8] = stb[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
    end
    return m;
  endfunction

  // Address decode. With zero wait states RESP is entered straight from the
  // accept edge, so in IDLE the live bus fields are decoded instead of the
  // (not yet loaded) capture registers.
  always_comb begin
    if (state_r == ST_IDLE) begin
      req_addr_s = PADDR;
      req_wstb_s = PWSTB;
    end else begin
      req_addr_s = addr_r;
      req_wstb_s = wstb_r;
    end
    offset_s   = (req_addr_s & 32'hFFFF_FFFC) - BASE_ADDR;
    hit_s      = (offset_s < WIN_BYTES);
    idx_s      = offset_s[AW+1:2];
    req_read_s = (req_wstb_s == 4'b0000);
    if (hit_s) begin
      rd_word_s = mem_r[idx_s];
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // Request FSM with registered PREADY/BUSY/PRDATA/ERR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      wstb_r   <= 4'b0000;
      cnt_r    <= 4'd0;
      pready_r <= 1'b0;
      busy_r   <= 1'b0;
      prdata_r <= 32'h0000_0000;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (PVALID) begin
            addr_r  <= PADDR;
            wdata_r <= PWDATA;
            wstb_r  <= PWSTB;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_r  <= ST_RESP;
              pready_r <= 1'b1;
              if (req_read_s) begin
                prdata_r <= rd_word_s;
              end
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A dropped PVALID abandons the request; it takes priority over
          // the last wait cycle so an aborted request never responds.
          if (!PVALID) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (cnt_r == WAIT_LAST) begin
            state_r  <= ST_RESP;
            pready_r <= 1'b1;
            if (req_read_s) begin
              prdata_r <= rd_word_s;
            end
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_RESP: begin
          state_r  <= ST_IDLE;
          pready_r <= 1'b0;
          busy_r   <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          pready_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase

      // A completing miss sets ERR even if a clear arrives in the same cycle.
      if ((state_r == ST_RESP) && !hit_s) begin
        err_r <= 1'b1;
      end else if (ERR_CLR) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // RAM write port: commits at the edge ending RESP. Gated by the reset-cleared
  // state so a reset during a request can never leave a partial write.
  always_ff @(posedge CLK) begin
    if ((state_r == ST_RESP) && hit_s && (wstb_r != 4'b0000)) begin
      mem_r[idx_s] <= lane_merge(mem_r[idx_s], wdata_r, wstb_r);
    end
  end

  assign PREADY = pready_r;
  assign PRDATA = prdata_r;
  assign ERR    = err_r;
  assign BUSY   = busy_r;

endmodule

// File: tb/tb_debug_pbus_target.sv
// Bench for debug_pbus_target: four instances with WAIT_CYCLES = 0, 1, 4, 15.
// Stimulus pushes the expected response into a queue; a monitor pops and
// compares whenever any instance raises PREADY.
module tb_debug_pbus_target;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        pv    [4];
  logic        rdy   [4];
  logic [3:0]  wstb  [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        err   [4];
  logic        clr   [4];
  logic        busy  [4];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    debug_pbus_target #(
      .BASE_ADDR   (32'h0000_0800),
      .DEPTH_WORDS (64),
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 4 : 15)
    ) u_dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .PVALID  (pv[g]),
      .PREADY  (rdy[g]),
      .PWSTB   (wstb[g]),
      .PADDR   (addr[g]),
      .PWDATA  (wdata[g]),
      .PRDATA  (rdata[g]),
      .ERR     (err[g]),
      .ERR_CLR (clr[g]),
      .BUSY    (busy[g])
    );
  end

  typedef struct {
    int          inst;
    bit          chk;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   prev_rdy [4];

  always @(posedge CLK) cyc <= cyc + 1;

  // Accept-to-PREADY latency for each instance (1 + WAIT_CYCLES).
  function automatic int exp_lat(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 16;
    endcase
  endfunction

  // Response monitor.
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (rdy[i] === 1'b1) begin
        exp_t e;
        total++;
        if (prev_rdy[i]) begin
          bad++;
          $display("FAIL pready_width inst=%0d got=more_than_1_cycle exp=1_cycle", i);
        end
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pready inst=%0d got=pready exp=none", i);
        end else begin
          e = sb_q.pop_front();
          total++;
          if (e.inst != i) begin
            bad++;
            $display("FAIL resp_inst got=%0d exp=%0d", i, e.inst);
          end
          total++;
          if ((cyc - e.acc) != exp_lat(i)) begin
            bad++;
            $display("FAIL latency inst=%0d got=%0d exp=%0d", i, cyc - e.acc, exp_lat(i));
          end
          if (e.chk) begin
            total++;
            if (rdata[i] !== e.data) begin
              bad++;
              $display("FAIL prdata inst=%0d got=%h exp=%h", i, rdata[i], e.data);
            end
          end
        end
      end
      prev_rdy[i] = (rdy[i] === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic start(input int i, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge CLK);
    pv[i]    = 1'b1;
    addr[i]  = a;
    wstb[i]  = s;
    wdata[i] = d;
  endtask

  // Full transaction: issue, garble the bus after accept, wait for PREADY
  // (bounded), optionally pulse ERR_CLR in the PREADY cycle, then release.
  task automatic xact(input int i, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit chk, input logic [31:0] exp,
                      input bit clr_at_resp);
    exp_t e;
    int   bcnt;
    bit   seen;
    start(i, a, s, d);
    e.inst = i; e.chk = chk; e.data = exp; e.acc = cyc;
    sb_q.push_back(e);
    bcnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge CLK);
      if (busy[i]) bcnt++;
      if (rdy[i]) begin
        seen = 1'b1;
        if (clr_at_resp) clr[i] = 1'b1;
      end
      if (k == 0) begin
        addr[i]  = ~a;
        wdata[i] = ~d;
        wstb[i]  = ~s;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL pready_timeout inst=%0d got=none exp=pready", i);
    end
    check("busy_span", 32'(bcnt), 32'(exp_lat(i)));
    @(posedge CLK);
    #1;
    pv[i]  = 1'b0;
    clr[i] = 1'b0;
    @(negedge CLK);
    check("busy_after", {31'd0, busy[i]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int any_rdy;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0; wstb[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0; clr[i] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      check("rst_pready", {31'd0, rdy[i]},  32'd0);
      check("rst_prdata", rdata[i],         32'h0);
      check("rst_err",    {31'd0, err[i]},  32'd0);
      check("rst_busy",   {31'd0, busy[i]}, 32'd0);
    end
    RST_N = 1'b1;

    // Basic write/read, 1 wait state.
    xact(1, 32'h0000_0800, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    xact(1, 32'h0000_0800, 4'h0, 32'h0,         1'b1, 32'h1234_5678, 1'b0);
    // Byte lanes.
    xact(1, 32'h0000_0804, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    xact(1, 32'h0000_0804, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0);
    xact(1, 32'h0000_0804, 4'h0, 32'h0,         1'b1, 32'hFFBB_FFDD, 1'b0);
    check("err_clean", {31'd0, err[1]}, 32'd0);
    // Out of window read below base.
    xact(1, 32'h0000_0700, 4'h0, 32'h0,         1'b1, 32'h0000_0000, 1'b0);
    check("err_after_read_miss", {31'd0, err[1]}, 32'd1);
    // Last word of the window is a hit.
    xact(1, 32'h0000_08FC, 4'hF, 32'h0F0F_0F0F, 1'b0, 32'h0, 1'b0);
    xact(1, 32'h0000_08FC, 4'h0, 32'h0,         1'b1, 32'h0F0F_0F0F, 1'b0);
    // First byte past the window is a miss and must not alias word 0.
    xact(1, 32'h0000_0900, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    check("err_after_write_miss", {31'd0, err[1]}, 32'd1);
    xact(1, 32'h0000_0800, 4'h0, 32'h0,         1'b1, 32'h1234_5678, 1'b0);
    // ERR_CLR pulse.
    @(negedge CLK); clr[1] = 1'b1;
    @(negedge CLK); clr[1] = 1'b0;
    check("err_cleared", {31'd0, err[1]}, 32'd0);
    // Miss coinciding with ERR_CLR: set wins.
    xact(1, 32'h0000_0700, 4'h0, 32'h0,         1'b1, 32'h0000_0000, 1'b1);
    check("err_set_wins", {31'd0, err[1]}, 32'd1);

    // Zero and fifteen wait states.
    xact(0, 32'h0000_0810, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0);
    xact(0, 32'h0000_0810, 4'h0, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0);
    xact(3, 32'h0000_0820, 4'hF, 32'h7654_3210, 1'b0, 32'h0, 1'b0);
    xact(3, 32'h0000_0820, 4'h0, 32'h0,         1'b1, 32'h7654_3210, 1'b0);

    // Abort in the second wait cycle, 4 wait states.
    xact(2, 32'h0000_0808, 4'hF, 32'h1111_2222, 1'b0, 32'h0, 1'b0);
    start(2, 32'h0000_0808, 4'hF, 32'h9999_9999);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    pv[2] = 1'b0;
    any_rdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (rdy[2]) any_rdy++;
    end
    check("abort_no_pready", 32'(any_rdy), 32'd0);
    check("abort_busy",      {31'd0, busy[2]}, 32'd0);
    check("abort_err",       {31'd0, err[2]},  32'd0);
    xact(2, 32'h0000_0808, 4'h0, 32'h0,         1'b1, 32'h1111_2222, 1'b0);

    // Reset in the middle of a write's wait phase.
    xact(2, 32'h0000_080C, 4'hF, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0);
    xact(2, 32'h0000_080C, 4'h0, 32'h0,         1'b1, 32'h5555_AAAA, 1'b0);
    start(2, 32'h0000_080C, 4'hF, 32'hDEAD_BEEF);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("rst_mid_pready", {31'd0, rdy[2]},  32'd0);
    check("rst_mid_busy",   {31'd0, busy[2]}, 32'd0);
    check("rst_mid_prdata", rdata[2],         32'h0);
    pv[2] = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    xact(2, 32'h0000_080C, 4'h0, 32'h0,         1'b1, 32'h5555_AAAA, 1'b0);

    repeat (4) @(negedge CLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_pbus_target.md
Name: debug_pbus_target

Overview:
- Responder end of the CPU-domain debug memory bus (PVALID/PREADY/PWSTB/PADDR/PWDATA/PRDATA).
- The debug bridge drives this bus as initiator.
- This block answers with a word-organised local RAM window: program buffer and debug data area.
- It provides configurable wait states, byte-strobe writes and out-of-window error reporting.
- It sits in the CPU clock domain beside the bridge. It gives the bench and the SoC a real target for debug memory and system accesses.

Parameters:
- BASE_ADDR, 32'h0000_0800, byte address of word 0 of the window.
- DEPTH_WORDS, 64, number of 32-bit words. Power of two, 2..1024.
- WAIT_CYCLES, 1, extra cycles between accept and PREADY. Range 0..15.

Ports:
- CLK  input  1  CPU clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- PVALID  input  1  request valid. The initiator holds it until it sees PREADY.
- PREADY  output  1  one-cycle response strobe.
- PWSTB  input  4  byte write strobes. 4'b0000 means read. Bit n enables PWDATA[8n+7:8n].
- PADDR  input  32  byte address. Bits [1:0] are ignored.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data. Valid in the PREADY cycle and held afterwards.
- ERR  output  1  sticky flag: an out-of-window access has occurred.
- ERR_CLR  input  1  synchronous clear of ERR.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, RST_N=0): state=IDLE, PREADY=0, PRDATA=0, ERR=0, wait counter=0. RAM contents are not reset.
- FSM states:
  - IDLE: PVALID=1 latches PADDR, PWSTB and PWDATA (accept, cycle T). Goes to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: counter counts WAIT_CYCLES cycles, then goes to RESP.
  - RESP: PREADY=1 for exactly one cycle, then goes to IDLE.
- Latency: PREADY is high in cycle T+1+WAIT_CYCLES.
- After RESP the block returns to IDLE. The initiator drops PVALID in the cycle after PREADY. A PVALID still high in IDLE is treated as a new request, because the initiator never holds it over.
- Hit test: offset = PADDR - BASE_ADDR (32-bit unsigned wrap). Hit if offset < DEPTH_WORDS*4. Word index = offset[log2(DEPTH_WORDS)+1:2].
- Write hit: at the clock edge ending the RESP cycle, only lanes with PWSTB bit set are updated. Other lanes are unchanged.
- Read hit: PRDATA is loaded with RAM[index] at the edge entering RESP. It is valid during PREADY and holds until the next completed read.
- Miss:
  - PREADY is still given with normal latency.
  - A read returns PRDATA=32'h0000_0000.
  - A write is dropped.
  - ERR is set at the edge ending RESP.
- ERR_CLR: clears ERR at the next edge. If a miss completes in the same cycle as ERR_CLR, set wins (ERR stays 1).
- Abort: if PVALID falls while in WAIT, the block returns to IDLE next cycle. No PREADY, no write, no PRDATA change, no ERR.
- PVALID in RESP is ignored (no abort).
- Request fields are captured only at accept. Changes to PADDR/PWDATA/PWSTB while BUSY are ignored.
- Reset asserted mid-transaction aborts immediately: no partial write, and PREADY goes low asynchronously.
- A read and a write never overlap; single outstanding request only.

Test Plan:
- WAIT_CYCLES=1. Write PADDR=0x800, PWSTB=4'hF, PWDATA=0x1234_5678, then read 0x800 → PREADY exactly 2 cycles after each accept. Read returns PRDATA=0x1234_5678.
- Byte lanes. Fill 0x804 with 0xFFFF_FFFF. Write PWSTB=4'b0101, PWDATA=0xAABB_CCDD → readback 0xFFBB_FFDD.
- Out of window. Read 0x700 → PRDATA=0, PREADY given, ERR=1. Write 0x900 (DEPTH_WORDS=64) → ERR stays 1 and RAM is unchanged. Pulse ERR_CLR → ERR=0. Miss coinciding with ERR_CLR → ERR=1.
- WAIT_CYCLES=0 and 15. Measure accept-to-PREADY latency → 1 and 16 cycles. BUSY high over exactly that span. PREADY width is always 1 cycle.
- Abort. WAIT_CYCLES=4, write 0x808, drop PVALID in the 2nd wait cycle → no PREADY. Readback of 0x808 shows the old value.
- Reset mid-WAIT during a write → PREADY=0, BUSY=0, PRDATA=0 immediately. RAM word unchanged. The next request completes normally.
